fft_peak_picker: RTL and testbench

// - Sits directly downstream of the FFT core's Avalon-ST source port; consumes one frame of FFT_PTS complex bins.
// - Computes per-bin power re^2+im^2 and tracks the strongest bin in the search band.
// - At end of frame, reports peak bin index and power for the pitch-estimation stage.
// - Malformed frames are flagged and produce no report.

---
 rtl/fft_pkg.sv | 15 +
 rtl/fft_power_calc.sv | 54 +++++
 rtl/fft_peak_picker.sv | 127 ++++++++++++
 tb/tb_fft_peak_picker.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and FSM encoding for the FFT peak picker.
package fft_pkg;
   localparam int FFT_PTS = 1024;
   localparam int DATA_W  = 16;
   localparam int BIN_W   = $clog2(FFT_PTS);
   localparam int MIN_BIN = 2;
   localparam int MAX_BIN = FFT_PTS / 2 - 1;
   localparam int POWER_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DRAIN   = 2'd2
   } state_t;
endpackage

// File: rtl/fft_power_calc.sv
// Two-stage re^2+im^2 pipeline; frame sideband (valid/sop/last/bin) travels alongside the data.
module fft_power_calc #(
   parameter int DATA_W = fft_pkg::DATA_W,
   parameter int BIN_W  = fft_pkg::BIN_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic                     in_sop,
   input  logic                     in_last,
   input  logic [BIN_W-1:0]         in_bin,
   input  logic signed [DATA_W-1:0] in_real,
   input  logic signed [DATA_W-1:0] in_imag,
   output logic                     out_valid,
   output logic                     out_sop,
   output logic                     out_last,
   output logic [BIN_W-1:0]         out_bin,
   output logic [31:0]              out_power
);
   logic signed [31:0] re_ext;
   logic signed [31:0] im_ext;
   logic               s1_valid;
   logic               s1_sop;
   logic               s1_last;
   logic [BIN_W-1:0]   s1_bin;
   logic [31:0]        s1_re_sq;
   logic [31:0]        s1_im_sq;

   assign re_ext = 32'(in_real);
   assign im_ext = 32'(in_imag);

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         s1_valid  <= in_valid;
         out_valid <= s1_valid;
      end
   end

   // Each square is at most 2^30 and the sum at most 2^31, so 32 unsigned bits never wrap.
   always_ff @(posedge clk) begin
      s1_sop    <= in_sop;
      s1_last   <= in_last;
      s1_bin    <= in_bin;
      s1_re_sq  <= re_ext * re_ext;
      s1_im_sq  <= im_ext * im_ext;
      out_sop   <= s1_sop;
      out_last  <= s1_last;
      out_bin   <= s1_bin;
      out_power <= s1_re_sq + s1_im_sq;
   end
endmodule

// File: rtl/fft_peak_picker.sv
// Frames FFT output beats, tracks the strongest in-band bin and reports it three cycles after eop.
module fft_peak_picker #(
   parameter int FFT_PTS = fft_pkg::FFT_PTS,
   parameter int DATA_W  = fft_pkg::DATA_W,
   parameter int MIN_BIN = fft_pkg::MIN_BIN,
   parameter int MAX_BIN = fft_pkg::MAX_BIN,
   parameter int BIN_W   = fft_pkg::BIN_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     source_valid,
   input  logic                     source_sop,
   input  logic                     source_eop,
   input  logic [1:0]               source_error,
   input  logic signed [DATA_W-1:0] source_real,
   input  logic signed [DATA_W-1:0] source_imag,
   output logic                     source_ready,
   output logic                     peak_valid,
   output logic [BIN_W-1:0]         peak_bin,
   output logic [31:0]              peak_power,
   output logic                     frame_error
);
   import fft_pkg::*;

   localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(FFT_PTS - 1);
   localparam logic [BIN_W-1:0] LO_BIN   = BIN_W'(MIN_BIN);
   localparam logic [BIN_W-1:0] HI_BIN   = BIN_W'(MAX_BIN);

   state_t           state;
   logic [BIN_W-1:0] bin_cnt;
   logic             drain_cnt;
   logic             accept;
   logic [BIN_W-1:0] beat_bin;
   logic             frame_beat;
   logic             beat_bad;
   logic             abort_old;
   logic             p_valid;
   logic             p_sop;
   logic             p_last;
   logic [BIN_W-1:0] p_bin;
   logic [31:0]      p_power;
   logic [BIN_W-1:0] max_bin;
   logic [31:0]      max_power;
   logic             report_d;

   // Handshake: a beat transfers on any cycle with source_valid & source_ready; ready is
   // low only in reset, so the FFT is never stalled and gaps in valid simply skip cycles.
   assign source_ready = ~reset;
   assign accept       = source_valid & source_ready;
   assign beat_bin     = source_sop ? '0 : bin_cnt;
   assign frame_beat   = accept & (source_sop | (state == ST_COLLECT));
   assign beat_bad     = (source_error != 2'b00) | (source_eop != (beat_bin == LAST_BIN));
   assign abort_old    = accept & source_sop & (state == ST_COLLECT);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         bin_cnt     <= '0;
         drain_cnt   <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         frame_error <= abort_old | (frame_beat & beat_bad);
         if (frame_beat) begin
            if (beat_bad) begin
               state   <= ST_IDLE;
               bin_cnt <= '0;
            end else if (source_eop) begin
               state     <= ST_DRAIN;
               drain_cnt <= 1'b0;
               bin_cnt   <= '0;
            end else begin
               state   <= ST_COLLECT;
               bin_cnt <= beat_bin + 1'b1;
            end
         end else if (state == ST_DRAIN) begin
            drain_cnt <= 1'b1;
            if (drain_cnt) state <= ST_IDLE;
         end
      end
   end

   fft_power_calc #(.DATA_W(DATA_W), .BIN_W(BIN_W)) u_power (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (frame_beat & ~beat_bad),
      .in_sop    (source_sop),
      .in_last   (source_eop),
      .in_bin    (beat_bin),
      .in_real   (source_real),
      .in_imag   (source_imag),
      .out_valid (p_valid),
      .out_sop   (p_sop),
      .out_last  (p_last),
      .out_bin   (p_bin),
      .out_power (p_power)
   );

   // The first in-band bin is always taken, so an all-zero band reports MIN_BIN with power 0
   // and later equal powers never displace the lower bin.
   always_ff @(posedge clk) begin
      if (reset) begin
         max_bin    <= '0;
         max_power  <= '0;
         report_d   <= 1'b0;
         peak_valid <= 1'b0;
         peak_bin   <= '0;
         peak_power <= '0;
      end else begin
         report_d   <= p_valid & p_last;
         peak_valid <= report_d;
         if (report_d) begin
            peak_bin   <= max_bin;
            peak_power <= max_power;
         end
         if (p_valid) begin
            if (p_sop) begin
               max_bin   <= '0;
               max_power <= '0;
            end else if (p_bin >= LO_BIN && p_bin <= HI_BIN &&
                         (p_power > max_power || p_bin == LO_BIN)) begin
               max_bin   <= p_bin;
               max_power <= p_power;
            end
         end
      end
   end
endmodule

// File: tb/tb_fft_peak_picker.sv
// Directed frames through fft_peak_picker with a queue-based scoreboard for reports and error pulses.
module tb_fft_peak_picker;
   import fft_pkg::*;

   localparam int N    = FFT_PTS;
   localparam int LAST = FFT_PTS - 1;

   logic                     clk = 1'b0;
   logic                     reset;
   logic                     source_valid;
   logic                     source_sop;
   logic                     source_eop;
   logic [1:0]               source_error;
   logic signed [DATA_W-1:0] source_real;
   logic signed [DATA_W-1:0] source_imag;
   logic                     source_ready;
   logic                     peak_valid;
   logic [BIN_W-1:0]         peak_bin;
   logic [31:0]              peak_power;
   logic                     frame_error;

   fft_peak_picker dut (
      .clk          (clk),
      .reset        (reset),
      .source_valid (source_valid),
      .source_sop   (source_sop),
      .source_eop   (source_eop),
      .source_error (source_error),
      .source_real  (source_real),
      .source_imag  (source_imag),
      .source_ready (source_ready),
      .peak_valid   (peak_valid),
      .peak_bin     (peak_bin),
      .peak_power   (peak_power),
      .frame_error  (frame_error)
   );

   // clock / reset block
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   logic [63:0] exp_q[$];   // {due_cycle[21:0], bin[9:0], power[31:0]}
   logic [31:0] err_q[$];   // due cycle of each frame_error pulse
   logic signed [DATA_W-1:0] re_a[N];
   logic signed [DATA_W-1:0] im_a[N];
   logic [BIN_W-1:0] hold_bin = '0;
   logic [31:0]      hold_power = '0;
   logic [63:0]      mon_e;
   logic [31:0]      mon_d;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // reference model: strongest bin in MIN_BIN..MAX_BIN, lower bin wins ties
   function automatic longint pw(input int b);
      return longint'(re_a[b]) * longint'(re_a[b]) + longint'(im_a[b]) * longint'(im_a[b]);
   endfunction

   function automatic logic [41:0] model_peak();
      int     best_b = MIN_BIN;
      longint best_p = pw(MIN_BIN);
      for (int b = MIN_BIN + 1; b <= MAX_BIN; b++) begin
         if (pw(b) > best_p) begin
            best_p = pw(b);
            best_b = b;
         end
      end
      return {10'(best_b), 32'(best_p)};
   endfunction

   // scoreboard consumer
   always @(negedge clk) begin
      if (!reset) begin
         if (peak_valid) begin
            checks++;
            assert (exp_q.size() != 0) else begin
               errors++;
               $error("FAIL unexpected_peak: observed peak_valid=1 bin %0d expected no pulse", peak_bin);
            end
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               chk("peak_latency", 64'(cyc), 64'(mon_e[63:42]));
               chk("peak_bin", 64'(peak_bin), 64'(mon_e[41:32]));
               chk("peak_power", 64'(peak_power), 64'(mon_e[31:0]));
               hold_bin   = mon_e[41:32];
               hold_power = mon_e[31:0];
            end
         end
         if (frame_error) begin
            checks++;
            assert (err_q.size() != 0) else begin
               errors++;
               $error("FAIL unexpected_frame_error: observed frame_error=1 at cycle %0d expected no pulse", cyc);
            end
            if (err_q.size() != 0) begin
               mon_d = err_q.pop_front();
               chk("frame_error_cycle", 64'(cyc), 64'(mon_d));
            end
         end
      end
   end

   // driver tasks
   task automatic drive_idle();
      source_valid = 1'b0;
      source_sop   = 1'b0;
      source_eop   = 1'b0;
      source_error = 2'b00;
   endtask

   task automatic clear_frame();
      for (int i = 0; i < N; i++) begin
         re_a[i] = '0;
         im_a[i] = '0;
      end
   endtask

   task automatic send_frame(input int nbeats, input int eop_at, input int err_bin,
                             input int gap_pct, input bit abort_prev);
      bit alive = 1'b1;
      bit bad;
      for (int i = 0; i < nbeats; i++) begin
         if (i > 0) begin
            while ($urandom_range(0, 99) < gap_pct) begin
               drive_idle();
               source_real = 16'($urandom);
               source_imag = 16'($urandom);
               @(posedge clk);
               #1;
            end
         end
         source_valid = 1'b1;
         source_sop   = (i == 0);
         source_eop   = (i == eop_at);
         source_error = (i == err_bin) ? 2'b01 : 2'b00;
         source_real  = re_a[i];
         source_imag  = im_a[i];
         @(posedge clk);
         #1;
         bad = (i == err_bin) || (i == eop_at && i != LAST) || (i == LAST && eop_at != LAST);
         if (alive && ((i == 0 && abort_prev) || bad)) err_q.push_back(32'(cyc));
         if (alive && bad) alive = 1'b0;
         else if (alive && i == eop_at) exp_q.push_back({22'(cyc + 3), model_peak()});
      end
      drive_idle();
   endtask

   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no completion by cycle %0d expected finish", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      drive_idle();
      source_real = '0;
      source_imag = '0;
      clear_frame();
      settle(3);
      chk("reset_ready", 64'(source_ready), 64'd0);
      chk("reset_peak_valid", 64'(peak_valid), 64'd0);
      chk("reset_peak_bin", 64'(peak_bin), 64'd0);
      chk("reset_peak_power", 64'(peak_power), 64'd0);
      chk("reset_frame_error", 64'(frame_error), 64'd0);
      reset = 1'b0;
      settle(1);
      chk("ready_after_reset", 64'(source_ready), 64'd1);

      // impulse at bin 100
      re_a[100] = 16'sd1000;
      send_frame(N, LAST, -1, 0, 1'b0);
      settle(6);

      // out-of-band energy must be ignored
      clear_frame();
      re_a[0]   = 16'sd30000;
      re_a[600] = 16'sd20000;
      re_a[40]  = 16'sd5;
      send_frame(N, LAST, -1, 20, 1'b0);
      settle(6);

      // tie at full-scale power, lower bin wins
      clear_frame();
      re_a[50] = -16'sd32768; im_a[50] = -16'sd32768;
      re_a[70] = -16'sd32768; im_a[70] = -16'sd32768;
      send_frame(N, LAST, -1, 0, 1'b0);
      settle(6);

      // short frame: error, outputs hold
      send_frame(501, 500, -1, 0, 1'b0);
      settle(8);
      chk("hold_bin_after_short", 64'(peak_bin), 64'(hold_bin));
      chk("hold_power_after_short", 64'(peak_power), 64'(hold_power));

      // source_error on bin 7, then a frame that never sees eop
      send_frame(N, LAST, 7, 10, 1'b0);
      settle(6);
      send_frame(N, -1, -1, 0, 1'b0);
      settle(6);
      chk("hold_bin_after_errors", 64'(peak_bin), 64'(hold_bin));

      // all-zero band reports MIN_BIN with power 0
      clear_frame();
      send_frame(N, LAST, -1, 0, 1'b0);
      settle(6);

      // sop while collecting aborts the old frame and starts a new one
      re_a[30] = 16'sd77;
      send_frame(50, -1, -1, 0, 1'b0);
      re_a[300] = 16'sd123;
      send_frame(N, LAST, -1, 0, 1'b1);
      settle(6);

      // back-to-back frames with random gaps
      clear_frame();
      re_a[200] = -16'sd300; im_a[200] = 16'sd400;
      re_a[512] = 16'sd32767;
      send_frame(N, LAST, -1, 30, 1'b0);
      clear_frame();
      re_a[511] = 16'sd7; im_a[511] = -16'sd7;
      im_a[2]   = 16'sd9;
      send_frame(N, LAST, -1, 30, 1'b0);
      settle(6);

      // reset on bin 300, then a clean frame
      clear_frame();
      re_a[9] = 16'sd100;
      send_frame(300, -1, -1, 0, 1'b0);
      reset = 1'b1;
      settle(2);
      chk("midreset_peak_valid", 64'(peak_valid), 64'd0);
      chk("midreset_peak_bin", 64'(peak_bin), 64'd0);
      chk("midreset_peak_power", 64'(peak_power), 64'd0);
      chk("midreset_frame_error", 64'(frame_error), 64'd0);
      reset = 1'b0;
      hold_bin   = '0;
      hold_power = '0;
      settle(3);
      send_frame(N, LAST, -1, 10, 1'b0);

      for (int k = 0; k < 20 && (exp_q.size() != 0 || err_q.size() != 0); k++) @(posedge clk);
      settle(2);
      chk("peaks_outstanding", 64'(exp_q.size()), 64'd0);
      chk("errors_outstanding", 64'(err_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
